// File: rtl/pin_io_sync_if.sv
// Pin bundle between the core/board side and the pin_io_sync front end.
// master = core + pads, slave = pin_io_sync.
interface pin_io_sync_if #(
   parameter int NUM_PINS = 32
);
   logic [NUM_PINS-1:0] pin_out;
   logic [NUM_PINS-1:0] pin_dir;
   logic [NUM_PINS-1:0] pad_in;
   logic [NUM_PINS-1:0] pad_out;
   logic [NUM_PINS-1:0] pad_oe;
   logic [NUM_PINS-1:0] prop_in;
   logic [NUM_PINS-1:0] rise;
   logic [NUM_PINS-1:0] fall;

   modport master (
      output pin_out, pin_dir, pad_in,
      input  pad_out, pad_oe, prop_in, rise, fall
   );

   modport slave (
      input  pin_out, pin_dir, pad_in,
      output pad_out, pad_oe, prop_in, rise, fall
   );
endinterface

// File: rtl/pin_io_sync.sv
// Pad I/O front end: synchronises pad inputs into clock_80, bypasses for driven pins,
// and produces rise/fall pulses. Optional glitch filter built with macro PIN_FILTER_EN.
module pin_io_sync #(
   parameter int                  NUM_PINS      = 32,
   parameter int                  SYNC_STAGES   = 2,
   parameter logic [NUM_PINS-1:0] INIT          = '0,
   parameter int                  FILTER_CYCLES = 4
) (
   input logic          clock_80,
   input logic          res,
   pin_io_sync_if.slave pins
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("pin_io_sync: SYNC_STAGES must be in 2..4");
   end
   if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("pin_io_sync: FILTER_CYCLES must be >= 1");
   end

   logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q, sync_d;
   logic [NUM_PINS-1:0]                  prev_q, prev_d;
   logic [NUM_PINS-1:0]                  s_last;
   logic [NUM_PINS-1:0]                  din;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = pins.pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   assign s_last = sync_q[SYNC_STAGES-1];

`ifdef PIN_FILTER_EN
   localparam int CW = $clog2(FILTER_CYCLES + 1);

   logic [NUM_PINS-1:0]          filt_q, filt_d;
   logic [NUM_PINS-1:0][CW-1:0]  cnt_q, cnt_d;

   // A pin's filtered value only moves after s_last has disagreed with it for
   // FILTER_CYCLES consecutive clocks; any agreement restarts the window.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      for (int i = 0; i < NUM_PINS; i++) begin
         if (s_last[i] == filt_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CW'(FILTER_CYCLES - 1)) begin
            filt_d[i] = s_last[i];
            cnt_d[i]  = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clock_80) begin
      if (res) begin
         filt_q <= INIT;
         cnt_q  <= '0;
      end else begin
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign din = filt_q;
`else
   assign din = s_last;
`endif

   // prev follows din even for output pins, so a direction switch never fakes an edge.
   always_comb begin
      prev_d = din;
   end

   always_ff @(posedge clock_80) begin
      if (res) begin
         sync_q <= {SYNC_STAGES{INIT}};
         prev_q <= INIT;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign pins.pad_out = pins.pin_out;
   assign pins.pad_oe  = pins.pin_dir;
   assign pins.prop_in = (pins.pin_dir & pins.pin_out) | (~pins.pin_dir & din);
   assign pins.rise    =  din & ~prev_q & ~pins.pin_dir;
   assign pins.fall    = ~din &  prev_q & ~pins.pin_dir;

endmodule

// File: tb/tb_pin_io_sync.sv
// Directed self-checking bench for pin_io_sync (NUM_PINS=8, SYNC_STAGES=3).
module tb_pin_io_sync;
   localparam int NP = 8;
   localparam int SS = 3;
   localparam int FC = 4;
`ifdef PIN_FILTER_EN
   localparam int LAT = SS + FC;
`else
   localparam int LAT = SS;
`endif

   logic clk = 1'b0;
   logic res = 1'b1;
   int   checks = 0;
   int   failures = 0;

   pin_io_sync_if #(.NUM_PINS(NP)) pif ();

   pin_io_sync #(
      .NUM_PINS(NP), .SYNC_STAGES(SS), .INIT('0), .FILTER_CYCLES(FC)
   ) dut (
      .clock_80(clk),
      .res(res),
      .pins(pif)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulse pad_in[2] high for w clocks and check pin 2 against the expected window.
   task automatic run_pulse(input int w);
      bit pass;
      int lat;
`ifdef PIN_FILTER_EN
      pass = (w >= FC);
      lat  = SS + FC;
`else
      pass = 1'b1;
      lat  = SS;
`endif
      pif.pad_in[2] = 1'b1;
      for (int k = 1; k <= SS + FC + w + 2; k++) begin
         step();
         chk($sformatf("pulse%0d_prop_k%0d", w, k), pif.prop_in,
             (pass && k >= lat && k < lat + w) ? 8'h04 : 8'h00);
         chk($sformatf("pulse%0d_rise_k%0d", w, k), pif.rise,
             (pass && k == lat) ? 8'h04 : 8'h00);
         chk($sformatf("pulse%0d_fall_k%0d", w, k), pif.fall,
             (pass && k == lat + w) ? 8'h04 : 8'h00);
         if (k == w) pif.pad_in[2] = 1'b0;
      end
   endtask

   initial begin
      logic t;
      pif.pin_out = '0;
      pif.pin_dir = '0;
      pif.pad_in  = '1;
      res         = 1'b1;

      // Reset hold with all pads high
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst_prop", pif.prop_in, 8'h00);
         chk("rst_rise", pif.rise, 8'h00);
         chk("rst_fall", pif.fall, 8'h00);
      end
      pif.pin_out = 8'hA5;
      #1;
      chk("rst_pad_out", pif.pad_out, 8'hA5);
      chk("rst_pad_oe", pif.pad_oe, 8'h00);
      pif.pin_out = '0;
      res = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         step();
         chk($sformatf("acq_prop_k%0d", k), pif.prop_in, (k >= LAT) ? 8'hFF : 8'h00);
         chk($sformatf("acq_rise_k%0d", k), pif.rise, (k == LAT) ? 8'hFF : 8'h00);
         chk($sformatf("acq_fall_k%0d", k), pif.fall, 8'h00);
      end

      // Pin 5 as output, toggling pin_out; bypass is combinational
      pif.pin_dir[5] = 1'b1;
      t = 1'b0;
      for (int k = 0; k < 6; k++) begin
         t = ~t;
         pif.pin_out[5] = t;
         #1;
         chk("byp_prop5", 8'(pif.prop_in[5]), 8'(t));
         chk("byp_pad_out5", 8'(pif.pad_out[5]), 8'(t));
         chk("byp_pad_oe", pif.pad_oe, 8'h20);
         step();
         chk("byp_rise", pif.rise, 8'h00);
         chk("byp_fall", pif.fall, 8'h00);
      end

      // Pad edge in flight while pin 5 is an output survives the switch to input
      pif.pin_out[5] = 1'b0;
      pif.pad_in[5]  = 1'b0;
      step();
      pif.pin_dir[5] = 1'b0;
      #1;
      chk("dir_sw_prop5", 8'(pif.prop_in[5]), 8'h01);
      chk("dir_sw_fall", pif.fall, 8'h00);
      for (int k = 2; k <= LAT + 1; k++) begin
         step();
         chk($sformatf("dir_prop5_k%0d", k), 8'(pif.prop_in[5]), (k >= LAT) ? 8'h00 : 8'h01);
         chk($sformatf("dir_fall_k%0d", k), pif.fall, (k == LAT) ? 8'h20 : 8'h00);
      end

      // All other pads low
      pif.pad_in = '0;
      for (int k = 1; k <= LAT + 1; k++) begin
         step();
         chk($sformatf("low_prop_k%0d", k), pif.prop_in, (k >= LAT) ? 8'h00 : 8'hDF);
         chk($sformatf("low_fall_k%0d", k), pif.fall, (k == LAT) ? 8'hDF : 8'h00);
      end

      // Pin 0 rising edge latency
      pif.pad_in[0] = 1'b1;
      for (int k = 1; k <= LAT + 1; k++) begin
         step();
         chk($sformatf("p0_prop_k%0d", k), pif.prop_in, (k >= LAT) ? 8'h01 : 8'h00);
         chk($sformatf("p0_rise_k%0d", k), pif.rise, (k == LAT) ? 8'h01 : 8'h00);
      end
      pif.pad_in[0] = 1'b0;
      for (int k = 0; k < LAT + 1; k++) step();
      chk("p0_back_low", pif.prop_in, 8'h00);

      // Glitch shorter than the window, then exactly the window
      run_pulse(FC - 1);
      run_pulse(FC);

      // Reset while an edge on pin 3 is inside the chain
      pif.pad_in[3] = 1'b1;
      step();
      step();
      res = 1'b1;
      step();
      chk("mid_rst_prop", pif.prop_in, 8'h00);
      chk("mid_rst_rise", pif.rise, 8'h00);
      res = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         step();
         chk($sformatf("reacq_prop_k%0d", k), pif.prop_in, (k >= LAT) ? 8'h08 : 8'h00);
         chk($sformatf("reacq_rise_k%0d", k), pif.rise, (k == LAT) ? 8'h08 : 8'h00);
         chk($sformatf("reacq_fall_k%0d", k), pif.fall, 8'h00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
